// File: rtl/hamming_dec_stream.sv
// Two-stage streaming (15,11) Hamming decoder with single-error correction and valid/ready backpressure.
// Optional saturating corrected-word counter (cnt_clr/err_cnt) is built only when HAM_ERR_CNT_EN is defined.
module hamming_dec_stream (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:1] cw_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:1] d_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_flag,
  output logic [3:0]  err_pos
`ifdef HAM_ERR_CNT_EN
  ,
  input  logic        cnt_clr,
  output logic [15:0] err_cnt
`endif
);

  // Handshake: a word moves on any edge where valid and ready are both high.
  // Each stage advances when it is empty or the stage after it advances, so
  // in_ready depends combinationally on out_ready.

  function automatic logic [3:0] syndrome(input logic [15:1] cw);
    logic [3:0] s;
    s = '0;
    for (int i = 1; i < 16; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (i[k]) s[k] = s[k] ^ cw[i];
      end
    end
    return s;
  endfunction

  // Data bit j lives at the j-th non-power-of-two position; flip it when the syndrome points there.
  function automatic logic [11:1] correct(input logic [15:1] cw, input logic [3:0] syn);
    logic [11:1] d;
    int          p;
    d = '0;
    for (int j = 1; j <= 11; j++) begin
      p    = (j == 1) ? 3 : ((j <= 4) ? j + 3 : j + 4);
      d[j] = cw[p] ^ (syn == 4'(p));
    end
    return d;
  endfunction

  logic        s1_valid;
  logic [15:1] s1_cw;
  logic [3:0]  s1_syn;
  logic        s1_adv;
  logic        s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cw  <= cw_in;
        s1_syn <= syndrome(cw_in);
      end
    end
  end

  // out_valid is the stage-2 valid bit; data only reloads when a new word enters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d_out     <= '0;
      err_flag  <= 1'b0;
      err_pos   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        d_out    <= correct(s1_cw, s1_syn);
        err_flag <= (s1_syn != 4'd0);
        err_pos  <= s1_syn;
      end
    end
  end

`ifdef HAM_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && err_flag && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hamming_dec_stream.sv
// Directed bench for hamming_dec_stream: vector table streamed through a scoreboard plus hand-written
// latency, backpressure, reset and (with HAM_ERR_CNT_EN) counter sequences.
module tb_hamming_dec_stream;

  logic        clk;
  logic        rst_n;
  logic [15:1] cw_in;
  logic        in_valid;
  logic        in_ready;
  logic [11:1] d_out;
  logic        out_valid;
  logic        out_ready;
  logic        err_flag;
  logic [3:0]  err_pos;
`ifdef HAM_ERR_CNT_EN
  logic        cnt_clr;
  logic [15:0] err_cnt;
`endif

  hamming_dec_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cw_in     (cw_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_out     (d_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_flag  (err_flag),
    .err_pos   (err_pos)
`ifdef HAM_ERR_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .err_cnt   (err_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [14:0] cw;
    logic [10:0] d;
    logic        flag;
    logic [3:0]  pos;
  } vec_t;

  localparam int NVEC = 21;
  vec_t        vecs[NVEC];
  logic [15:0] exp_q[$];
  int          total;
  int          bad;
  int          out_cnt;
  logic        mon_en;
  logic        saw_stall;
  logic        held_v;
  logic [15:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pack(input vec_t v);
    return {v.d, v.flag, v.pos};
  endfunction

  // Output monitor: every output transfer is matched against the expected queue,
  // and a stalled output must be unchanged on the following cycle.
  always @(negedge clk) begin
    logic [15:0] e;
    if (mon_en && rst_n) begin
      if (held_v) chk("hold_stable", {16'd0, d_out, err_flag, err_pos}, {16'd0, held});
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_output: got %0h expected none", {d_out, err_flag, err_pos});
        end else begin
          e = exp_q.pop_front();
          chk("out_word", {16'd0, d_out, err_flag, err_pos}, {16'd0, e});
        end
      end
      held_v = out_valid && !out_ready;
      held   = {d_out, err_flag, err_pos};
    end else begin
      held_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Present one word until accepted; in_ready is checked against the occupancy model before the push.
  task automatic send(input logic [14:0] cw, input logic [15:0] exp);
    int   waited;
    logic done;
    waited   = 0;
    done     = 1'b0;
    cw_in    = cw;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      chk("in_ready", {31'd0, in_ready}, {31'd0, ((exp_q.size() < 2) || out_ready)});
      if (in_ready) begin
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        done     = 1'b1;
      end else begin
        saw_stall = 1'b1;
        @(posedge clk);
        #1;
        waited++;
        if (waited > 50) begin
          total++;
          bad++;
          $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", waited);
          in_valid = 1'b0;
          done     = 1'b1;
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int start_cnt;
    int flagged;
    rst_n     = 1'b0;
    cw_in     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total     = 0;
    bad       = 0;
    out_cnt   = 0;
    mon_en    = 1'b0;
    saw_stall = 1'b0;
    held_v    = 1'b0;
    held      = '0;
`ifdef HAM_ERR_CNT_EN
    cnt_clr   = 1'b0;
`endif

    vecs[0] = '{15'h0000, 11'h000, 1'b0, 4'd0};
    vecs[1] = '{15'h7FFF, 11'h7FF, 1'b0, 4'd0};
    vecs[2] = '{15'h7FEF, 11'h7FF, 1'b1, 4'd5};
    vecs[3] = '{15'h7F7F, 11'h7FF, 1'b1, 4'd8};
    vecs[4] = '{15'h0007, 11'h001, 1'b0, 4'd0};   // d=1 with p1,p2 set
    vecs[5] = '{15'h4007, 11'h001, 1'b1, 4'd15};
    for (int k = 1; k <= 15; k++) begin
      vecs[5 + k] = '{15'(15'd1 << (k - 1)), 11'h000, 1'b1, 4'(k)};
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_d_out", {21'd0, d_out}, 0);
    chk("rst_err_flag", {31'd0, err_flag}, 0);
    chk("rst_err_pos", {28'd0, err_pos}, 0);
`ifdef HAM_ERR_CNT_EN
    chk("rst_err_cnt", {16'd0, err_cnt}, 0);
`endif
    rst_n = 1'b1;

    // Latency: word presented in the cycle starting at edge n is out after edge n+2
    @(posedge clk);
    #1;
    cw_in    = 15'h0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    cw_in = 15'h7FFF;
    chk("lat_n1_valid", {31'd0, out_valid}, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_w0_valid", {31'd0, out_valid}, 1);
    chk("lat_w0_data", {16'd0, d_out, err_flag, err_pos}, {16'd0, 11'h000, 1'b0, 4'd0});
    @(posedge clk);
    #1;
    chk("lat_w1_valid", {31'd0, out_valid}, 1);
    chk("lat_w1_data", {16'd0, d_out, err_flag, err_pos}, {16'd0, 11'h7FF, 1'b0, 4'd0});
    @(posedge clk);
    #1;
    chk("lat_idle_valid", {31'd0, out_valid}, 0);
`ifdef HAM_ERR_CNT_EN
    do_reset();
`endif

    // Vector table streamed back to back
    mon_en    = 1'b1;
    start_cnt = out_cnt;
    flagged   = 0;
    for (int i = 0; i < NVEC; i++) begin
      send(vecs[i].cw, pack(vecs[i]));
      if (vecs[i].flag) flagged++;
    end
    drain();
    chk("table_count", out_cnt - start_cnt, NVEC);
`ifdef HAM_ERR_CNT_EN
    chk("table_err_cnt", {16'd0, err_cnt}, flagged);
`endif

    // Backpressure: out_ready low for cycles 2..6 of a 5-word stream
    start_cnt = out_cnt;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 2; i < 7; i++) send(vecs[i].cw, pack(vecs[i]));
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_stall_seen", {31'd0, saw_stall}, 1);
    chk("bp_count", out_cnt - start_cnt, 5);

    // Reset with two words in flight
    out_ready = 1'b0;
    send(15'h7FEF, {11'h7FF, 1'b1, 4'd5});
    send(15'h4007, {11'h001, 1'b1, 4'd15});
    mon_en = 1'b0;
    chk("full_in_ready", {31'd0, in_ready}, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
    chk("mid_rst_data", {16'd0, d_out, err_flag, err_pos}, 0);
`ifdef HAM_ERR_CNT_EN
    chk("mid_rst_err_cnt", {16'd0, err_cnt}, 0);
`endif
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_stale", {31'd0, out_valid}, 0);
    end
    mon_en = 1'b1;

`ifdef HAM_ERR_CNT_EN
    // Counter: single data error, saturation, then clear against a same-cycle increment
    send(15'h7FEF, {11'h7FF, 1'b1, 4'd5});
    drain();
    chk("cnt_first", {16'd0, err_cnt}, 1);
    for (int i = 0; i < 65537; i++) send(15'h0001, {11'h000, 1'b1, 4'd1});
    drain();
    chk("cnt_saturate", {16'd0, err_cnt}, 32'hFFFF);
    fork
      begin
        for (int i = 0; i < 4; i++) send(15'h0002, {11'h000, 1'b1, 4'd2});
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        cnt_clr = 1'b1;
        @(negedge clk);
        chk("clr_same_cycle_xfer", {31'd0, out_valid && out_ready && err_flag}, 1);
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("cnt_clr_wins", {16'd0, err_cnt}, 0);
      end
    join
    drain();
    chk("cnt_after_clr", {16'd0, err_cnt}, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
